env_gen: RTL

ADSR envelope generator and amplitude stage for one SID voice. It sits directly downstream of the `acc` oscillator and consumes the voice's 12-bit waveform sample, with the gate taken from the same `control` register. It steps an 8-bit envelope through attack, decay/sustain and release at table-driven rates, then scales the waveform by the envelope. The scaled sample is passed to the voice mixer.

---
 rtl/env_gen_if.sv | 21 ++
 rtl/env_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/env_gen_if.sv
// Voice-side bus for env_gen: control/ADSR registers and waveform in,
// envelope level, scaled sample and phase out.
interface env_gen_if;
  logic [7:0]  control;
  logic [7:0]  ad;
  logic [7:0]  sr;
  logic [11:0] waveIn;
  logic [7:0]  envOut;
  logic [11:0] ampOut;
  logic [1:0]  stateOut;

  modport master (
    output control, ad, sr, waveIn,
    input  envOut, ampOut, stateOut
  );

  modport slave (
    input  control, ad, sr, waveIn,
    output envOut, ampOut, stateOut
  );
endinterface

// File: rtl/env_gen.sv
// SID voice ADSR envelope generator and amplitude stage.
// Optional macro ENV_EXP_DECAY_EN enables the exponential decay/release divider.
module env_gen #(
  parameter int RATE_W = 15
) (
  input logic      clk,
  input logic      rst,
  env_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_DECAY   = 2'd2
  } state_t;

  state_t              state_r;
  logic [7:0]          env_r;
  logic [11:0]         amp_r;
  logic [RATE_W-1:0]   rate_cnt_r;
  logic                gate_prev_r;

  logic                gate_s;
  logic                rise_s;
  logic                fall_s;
  logic [3:0]          rate_idx_s;
  logic [RATE_W-1:0]   period_s;
  logic                tick_s;
  logic                exp_hit_s;
  logic                step_s;
  logic [7:0]          sustain_s;
  logic [19:0]         prod_s;
  logic                unused_s;

  function automatic logic [RATE_W-1:0] rate_period(input logic [3:0] idx);
    case (idx)
      4'd0:    rate_period = RATE_W'(9);
      4'd1:    rate_period = RATE_W'(32);
      4'd2:    rate_period = RATE_W'(63);
      4'd3:    rate_period = RATE_W'(95);
      4'd4:    rate_period = RATE_W'(149);
      4'd5:    rate_period = RATE_W'(220);
      4'd6:    rate_period = RATE_W'(267);
      4'd7:    rate_period = RATE_W'(313);
      4'd8:    rate_period = RATE_W'(392);
      4'd9:    rate_period = RATE_W'(977);
      4'd10:   rate_period = RATE_W'(1954);
      4'd11:   rate_period = RATE_W'(3126);
      4'd12:   rate_period = RATE_W'(3907);
      4'd13:   rate_period = RATE_W'(11720);
      4'd14:   rate_period = RATE_W'(19532);
      default: rate_period = RATE_W'(31251);
    endcase
  endfunction

  assign gate_s    = bus.control[0];
  assign rise_s    = gate_s & ~gate_prev_r;
  assign fall_s    = ~gate_s & gate_prev_r;
  assign sustain_s = {bus.sr[7:4], bus.sr[7:4]};
  assign prod_s    = 20'(bus.waveIn) * 20'(env_r);
  assign unused_s  = ^{bus.control[7:1], prod_s[7:0]};

  // Rate index follows the current phase.
  always_comb begin
    case (state_r)
      ST_ATTACK: rate_idx_s = bus.ad[7:4];
      ST_DECAY:  rate_idx_s = bus.ad[3:0];
      default:   rate_idx_s = bus.sr[3:0];
    endcase
  end

  assign period_s = rate_period(rate_idx_s);
  // >= rather than == so a period shortened mid-count fires at once.
  assign tick_s   = (rate_cnt_r >= (period_s - RATE_W'(1)));

`ifdef ENV_EXP_DECAY_EN
  logic [4:0] exp_cnt_r;
  logic [4:0] exp_div_s;

  // Piecewise divisor approximating an exponential fall-off.
  always_comb begin
    if (env_r > 8'd93) begin
      exp_div_s = 5'd1;
    end else if (env_r > 8'd54) begin
      exp_div_s = 5'd2;
    end else if (env_r > 8'd26) begin
      exp_div_s = 5'd4;
    end else if (env_r > 8'd14) begin
      exp_div_s = 5'd8;
    end else if (env_r > 8'd6) begin
      exp_div_s = 5'd16;
    end else begin
      exp_div_s = 5'd30;
    end
  end

  assign exp_hit_s = (exp_cnt_r >= (exp_div_s - 5'd1));
`else
  assign exp_hit_s = 1'b1;
`endif

  assign step_s = tick_s & ((state_r == ST_ATTACK) | exp_hit_s);

  // Envelope state machine, rate/exp counters and amplitude register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_RELEASE;
      env_r       <= 8'd0;
      amp_r       <= 12'd0;
      rate_cnt_r  <= '0;
      gate_prev_r <= 1'b0;
`ifdef ENV_EXP_DECAY_EN
      exp_cnt_r   <= 5'd0;
`endif
    end else begin
      gate_prev_r <= gate_s;
      amp_r       <= prod_s[19:8];
      if (rise_s) begin
        state_r    <= ST_ATTACK;
        rate_cnt_r <= '0;
`ifdef ENV_EXP_DECAY_EN
        exp_cnt_r  <= 5'd0;
`endif
      end else if (fall_s) begin
        state_r    <= ST_RELEASE;
        rate_cnt_r <= '0;
      end else begin
        if (tick_s) begin
          rate_cnt_r <= '0;
        end else begin
          rate_cnt_r <= rate_cnt_r + RATE_W'(1);
        end
`ifdef ENV_EXP_DECAY_EN
        if (tick_s && (state_r != ST_ATTACK)) begin
          exp_cnt_r <= exp_hit_s ? 5'd0 : (exp_cnt_r + 5'd1);
        end
`endif
        if (step_s) begin
          case (state_r)
            ST_ATTACK: begin
              if (env_r != 8'd255) begin
                env_r <= env_r + 8'd1;
              end
              if (env_r >= 8'd254) begin
                state_r <= ST_DECAY;
              end
            end
            ST_DECAY: begin
              if (env_r > sustain_s) begin
                env_r <= env_r - 8'd1;
              end
            end
            default: begin
              if (env_r != 8'd0) begin
                env_r <= env_r - 8'd1;
              end
            end
          endcase
        end
      end
    end
  end

  assign bus.envOut   = env_r;
  assign bus.ampOut   = amp_r;
  assign bus.stateOut = state_r;

endmodule
